// File: rtl/pifo_pkg.sv
// Shared types for the PIFO request master: command opcodes and the
// drain state machine encoding.
package pifo_pkg;

   typedef enum logic {
      PIFO_OP_PUSH = 1'b0,
      PIFO_OP_POP  = 1'b1
   } pifo_op_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } pifo_state_e;

endpackage

// File: rtl/pifo_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding pop results until the
// client takes them. Writes on full and reads on empty are ignored.
module pifo_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 18
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_rd,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             wr_ok, rd_ok;

   always_comb begin
      o_full  = (cnt_q == CNT_MAX);
      o_empty = (cnt_q == '0);
      o_count = cnt_q;
      o_rdata = mem_q[rptr_q];
      wr_ok   = i_wr & ~o_full;
      rd_ok   = i_rd & ~o_empty;
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      if (wr_ok) begin
         mem_d[wptr_q] = i_wdata;
         wptr_d        = wptr_q + PTR_ONE;
      end
      if (rd_ok) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      unique case ({wr_ok, rd_ok})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: nothing is visible until the count says so.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pifo_req_master.sv
// Client-side request master for a PIFO tree level: issues push/pop
// requests, tracks pop credits and buffers pop results in arrival order.
module pifo_req_master
   import pifo_pkg::*;
#(
   parameter int PTW       = 16,
   parameter int MTW       = 0,
   parameter int TREE_NUM  = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_cmd_valid,
   output logic                           o_cmd_ready,
   input  logic                           i_cmd_op,
   input  logic [$clog2(TREE_NUM)-1:0]    i_cmd_tree_id,
   input  logic [PTW+MTW-1:0]             i_cmd_data,
   output logic                           o_push,
   output logic                           o_pop,
   output logic [$clog2(TREE_NUM)-1:0]    o_push_tree_id,
   output logic [$clog2(TREE_NUM)-1:0]    o_pop_tree_id,
   output logic [PTW+MTW-1:0]             o_push_data,
   input  logic                           i_task_fifo_full,
   input  logic                           i_is_level0_pop,
   input  logic [PTW+MTW-1:0]             i_pop_data,
   input  logic [$clog2(TREE_NUM)-1:0]    i_pop_tree_id,
   output logic                           o_rsp_valid,
   input  logic                           i_rsp_ready,
   output logic [PTW+MTW-1:0]             o_rsp_data,
   output logic [$clog2(TREE_NUM)-1:0]    o_rsp_tree_id,
   output logic                           o_rsp_empty,
   input  logic                           i_drain,
   output logic                           o_drained,
   output logic                           o_err,
   output logic [$clog2(RSP_DEPTH):0]     o_credits_used
);

   localparam int DW  = PTW + MTW;
   localparam int TNB = $clog2(TREE_NUM);
   localparam int CW  = $clog2(RSP_DEPTH) + 1;
   localparam int FW  = DW + TNB;
   localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   pifo_state_e      state_q, state_d;
   logic [CW-1:0]    credits_q, credits_d;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic             push_q, push_d;
   logic             pop_q, pop_d;
   logic [TNB-1:0]   push_tree_q, push_tree_d;
   logic [TNB-1:0]   pop_tree_q, pop_tree_d;
   logic [DW-1:0]    push_data_q, push_data_d;
   logic             err_q, err_d;

   pifo_op_e         cmd_op;
   logic             cmd_ready;
   logic             accept;
   logic             pop_issue;
   logic             push_issue;
   logic             issued;
   logic             rsp_hs;
   logic             res_ok;
   logic             res_bad;
   logic             idle;

   logic [FW-1:0]    fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_cnt;

   pifo_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (FW)
   ) u_rsp_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wr    (res_ok),
      .i_wdata ({i_pop_tree_id, i_pop_data}),
      .i_rd    (rsp_hs),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_cnt)
   );

   always_comb begin
      cmd_op     = pifo_op_e'(i_cmd_op);
      issued     = push_q | pop_q;
      // Pops must reserve a response slot before they may leave.
      cmd_ready  = (state_q == ST_RUN) & ~i_task_fifo_full & ~issued &
                   ((cmd_op == PIFO_OP_PUSH) | (credits_q < CRED_MAX));
      accept     = i_cmd_valid & cmd_ready;
      pop_issue  = accept & (cmd_op == PIFO_OP_POP);
      push_issue = accept & (cmd_op == PIFO_OP_PUSH);
      rsp_hs     = ~fifo_empty & i_rsp_ready;
      res_ok     = i_is_level0_pop & (inflight_q != '0);
      res_bad    = i_is_level0_pop & (inflight_q == '0);
      idle       = (inflight_q == '0) & (credits_q == '0) &
                   (fifo_cnt == '0) & ~issued;

      push_d      = push_issue;
      pop_d       = pop_issue;
      push_tree_d = push_issue ? i_cmd_tree_id : '0;
      push_data_d = push_issue ? i_cmd_data : '1;
      pop_tree_d  = pop_issue ? i_cmd_tree_id : '0;
      err_d       = err_q | res_bad | (res_ok & fifo_full);

      credits_d = credits_q;
      unique case ({pop_issue, rsp_hs})
         2'b10:   credits_d = credits_q + CNT_ONE;
         2'b01:   credits_d = credits_q - CNT_ONE;
         default: credits_d = credits_q;
      endcase

      inflight_d = inflight_q;
      unique case ({pop_issue, res_ok})
         2'b10:   inflight_d = inflight_q + CNT_ONE;
         2'b01:   inflight_d = inflight_q - CNT_ONE;
         default: inflight_d = inflight_q;
      endcase

      state_d = state_q;
      unique case (state_q)
         ST_RUN:   if (i_drain) state_d = ST_DRAIN;
         ST_DRAIN: if (idle)    state_d = ST_DONE;
         ST_DONE:  if (!i_drain) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_RUN;
         credits_q   <= '0;
         inflight_q  <= '0;
         push_q      <= 1'b0;
         pop_q       <= 1'b0;
         push_tree_q <= '0;
         pop_tree_q  <= '0;
         push_data_q <= '1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         credits_q   <= credits_d;
         inflight_q  <= inflight_d;
         push_q      <= push_d;
         pop_q       <= pop_d;
         push_tree_q <= push_tree_d;
         pop_tree_q  <= pop_tree_d;
         push_data_q <= push_data_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      o_cmd_ready    = cmd_ready;
      o_push         = push_q;
      o_pop          = pop_q;
      o_push_tree_id = push_tree_q;
      o_pop_tree_id  = pop_tree_q;
      o_push_data    = push_data_q;
      o_rsp_valid    = ~fifo_empty;
      o_rsp_data     = fifo_rdata[DW-1:0];
      o_rsp_tree_id  = fifo_rdata[FW-1:DW];
      o_rsp_empty    = (fifo_rdata[DW-1:0] == '1);
      o_drained      = (state_q == ST_DONE);
      o_err          = err_q;
      o_credits_used = credits_q;
   end

endmodule
